issue_scoreboard_ctrl: RTL and testbench

- Dual-issue, in-order issue controller that sits between fetch and the two decode lanes.
- Keeps a per-register pending-write scoreboard over the 8 architectural registers.
- Each cycle it decides whether slot 0 and slot 1 may enter decode, and drives the per-lane stalls.
- Clears scoreboard entries from the two writeback buses, and rolls back entries of instructions squashed by a taken branch.

---
 rtl/isa_pkg.sv | 68 ++++++
 rtl/issue_scoreboard_ctrl_hazard_check.sv | 32 +++
 rtl/issue_scoreboard_ctrl.sv | 131 +++++++++++++
 tb/tb_issue_scoreboard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA definitions shared by the issue controller: field layout, opcode
// classes and the writeback bus format.
package isa_pkg;

    localparam int RD_W = 3;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_WR_LO   = 4'h1;
    localparam logic [3:0] OP_WR_HI   = 4'h9;
    localparam logic [3:0] OP_STORE_A = 4'hA;
    localparam logic [3:0] OP_STORE_B = 4'hB;
    localparam logic [3:0] OP_BR_LO   = 4'hC;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int IMM_BIT = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;

    localparam int WB_INVALID_BIT = 19;

    typedef struct packed {
        logic [3:0]      op;
        logic            imm;
        logic [RD_W-1:0] rd;
        logic [RD_W-1:0] rs1;
        logic [RD_W-1:0] rs2;
    } instr_t;

    // Writeback bus: the top bit is an active-low valid.
    typedef struct packed {
        logic            inv;
        logic [15:0]     val;
        logic [RD_W-1:0] rd;
    } wb_t;

    function automatic instr_t decode(input logic [15:0] raw);
        instr_t d;
        d.op  = raw[OP_MSB:OP_LSB];
        d.imm = raw[IMM_BIT];
        d.rd  = raw[RD_MSB:RD_LSB];
        d.rs1 = raw[RS1_MSB:RS1_LSB];
        d.rs2 = raw[RS2_MSB:RS2_LSB];
        return d;
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= OP_WR_LO) && (op <= OP_WR_HI);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return op >= OP_BR_LO;
    endfunction

    // Stores read rd as their data source instead of writing it.
    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_STORE_A) || (op == OP_STORE_B);
    endfunction

    function automatic logic uses_rs2(input instr_t i);
        return !i.imm;
    endfunction

endpackage

// File: rtl/issue_scoreboard_ctrl_hazard_check.sv
// Per-slot readiness against the scoreboard: source operands (with
// writeback forwarding) and the write-after-write check on rd.
module hazard_check
    import isa_pkg::*;
#(
    parameter int NREG = 8
) (
    input  instr_t                     ins_i,
    input  logic [NREG-1:0]            pend_i,
    input  logic [1:0]                 wb_vld_i,
    input  logic [1:0][RD_W-1:0]       wb_rd_i,
    output logic                       src_ok_o,
    output logic                       waw_ok_o
);

    logic [NREG-1:0] rdy;

    // A register is usable if not pending or being written back right now.
    always_comb begin
        rdy = ~pend_i;
        for (int k = 0; k < 2; k++) begin
            if (wb_vld_i[k]) rdy[wb_rd_i[k]] = 1'b1;
        end
    end

    assign src_ok_o = rdy[ins_i.rs1]
                    & (~uses_rs2(ins_i)     | rdy[ins_i.rs2])
                    & (~is_store(ins_i.op)  | rdy[ins_i.rd]);

    assign waw_ok_o = ~writes_rd(ins_i.op) | rdy[ins_i.rd];

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Dual-issue in-order issue controller with a pending-write scoreboard,
// writeback clearing, branch-flush rollback and a stall watchdog.
module issue_scoreboard_ctrl
    import isa_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     instr0,
    input  logic            valid0,
    input  logic [15:0]     instr1,
    input  logic            valid1,
    input  logic [19:0]     wb0,
    input  logic [19:0]     wb1,
    input  logic            is_branch_taken,
    output logic            issue0,
    output logic            issue1,
    output logic            stall0,
    output logic            stall1,
    output logic [NREG-1:0] pending,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    instr_t [1:0]          ins;
    wb_t                   w0, w1;
    logic [1:0]            wb_vld;
    logic [1:0][RD_W-1:0]  wb_rd;
    logic [1:0]            src_ok, waw_ok;
    logic                  wr0, wr1, raw01, waw01;

    logic [NREG-1:0]       pending_q, pending_d;
    logic [1:0]            iss_vld_q, iss_vld_d;
    logic [1:0][RD_W-1:0]  iss_rd_q, iss_rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q;

    assign ins[0] = decode(instr0);
    assign ins[1] = decode(instr1);
    assign w0     = wb_t'(wb0);
    assign w1     = wb_t'(wb1);
    assign wb_vld = {~w1.inv, ~w0.inv};
    assign wb_rd  = {w1.rd, w0.rd};

    // Forwarded values and the reserved instruction bits are decode's concern.
    logic unused_bits;
    assign unused_bits = ^{w0.val, w1.val, instr0[1:0], instr1[1:0]};

    for (genvar s = 0; s < 2; s++) begin : g_slot
        hazard_check #(.NREG(NREG)) u_hz (
            .ins_i    (ins[s]),
            .pend_i   (pending_q),
            .wb_vld_i (wb_vld),
            .wb_rd_i  (wb_rd),
            .src_ok_o (src_ok[s]),
            .waw_ok_o (waw_ok[s])
        );
    end

    assign wr0 = writes_rd(ins[0].op);
    assign wr1 = writes_rd(ins[1].op);

    // Slot 1 may not consume or overwrite what slot 0 produces this cycle.
    assign raw01 = wr0 & ( (ins[1].rs1 == ins[0].rd)
                         | (uses_rs2(ins[1])    & (ins[1].rs2 == ins[0].rd))
                         | (is_store(ins[1].op) & (ins[1].rd  == ins[0].rd)) );
    assign waw01 = wr0 & wr1 & (ins[1].rd == ins[0].rd);

    assign issue0 = ~reset & valid0 & src_ok[0] & waw_ok[0] & ~is_branch_taken;
    assign issue1 = issue0 & valid1 & src_ok[1] & waw_ok[1]
                  & ~raw01 & ~waw01 & ~is_branch(ins[0].op);
    assign stall0 = ~reset & valid0 & ~issue0;
    assign stall1 = ~reset & valid1 & ~issue1;

    // Next scoreboard: writeback clears, flush rollback, then issue sets win.
    always_comb begin
        pending_d = pending_q;
        for (int k = 0; k < 2; k++) begin
            if (wb_vld[k]) pending_d[wb_rd[k]] = 1'b0;
        end
        if (is_branch_taken) begin
            for (int k = 0; k < 2; k++) begin
                if (iss_vld_q[k]) pending_d[iss_rd_q[k]] = 1'b0;
            end
        end
        if (issue0 && wr0) pending_d[ins[0].rd] = 1'b1;
        if (issue1 && wr1) pending_d[ins[1].rd] = 1'b1;
        // Nothing issues on a flush, so this also empties the tracking set.
        iss_vld_d = {issue1 & wr1, issue0 & wr0};
        iss_rd_d  = {ins[1].rd, ins[0].rd};
    end

    // Consecutive slot-0 stall cycles, saturating at TIMEOUT.
    always_comb begin
        cnt_d = '0;
        if (valid0 && !issue0) begin
            cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Scoreboard and last-cycle issued-writer tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            iss_vld_q <= '0;
            iss_rd_q  <= '0;
        end else begin
            pending_q <= pending_d;
            iss_vld_q <= iss_vld_d;
            iss_rd_q  <= iss_rd_d;
        end
    end

    // Stall watchdog with a sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(TIMEOUT)) err_q <= 1'b1;
        end
    end

    assign pending     = pending_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Scoreboard bench: the driver predicts each cycle's response from a
// queue/array model of the issue rules; a negedge monitor checks it.
module tb_issue_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr0, instr1;
    logic        valid0, valid1;
    logic [19:0] wb0, wb1;
    logic        is_branch_taken;
    logic        issue0, issue1, stall0, stall1;
    logic [7:0]  pending;
    logic        timeout_err;

    localparam logic [19:0] WB_NONE = 20'h80000;

    always #5 clk = ~clk;

    issue_scoreboard_ctrl #(.NREG(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .instr0(instr0), .valid0(valid0), .instr1(instr1), .valid1(valid1),
        .wb0(wb0), .wb1(wb1), .is_branch_taken(is_branch_taken),
        .issue0(issue0), .issue1(issue1), .stall0(stall0), .stall1(stall1),
        .pending(pending), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic       i0, i1, s0, s1;
        logic [7:0] pend;
        logic       err;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state
    bit   mp[8];
    int   mis[$];
    int   mcnt;
    bit   merr;

    function automatic logic [15:0] mk(input int op, input int imm, input int rd,
                                       input int rs1, input int rs2);
        return {op[3:0], imm[0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00};
    endfunction

    function automatic logic [19:0] wbv(input int rd, input logic [15:0] v);
        return {1'b0, v, rd[2:0]};
    endfunction

    function automatic bit wbhit(input int r);
        return (wb0[19] == 1'b0 && int'(wb0[2:0]) == r) ||
               (wb1[19] == 1'b0 && int'(wb1[2:0]) == r);
    endfunction

    function automatic bit ready(input int r);
        return !mp[r] || wbhit(r);
    endfunction

    // Registers an instruction reads: rs1, rs2 unless immediate, rd for stores.
    function automatic void sources(input logic [15:0] ins, output int q[$]);
        int op;
        op = int'(ins[15:12]);
        q.delete();
        q.push_back(int'(ins[7:5]));
        if (ins[11] == 1'b0) q.push_back(int'(ins[4:2]));
        if (op == 10 || op == 11) q.push_back(int'(ins[10:8]));
    endfunction

    function automatic bit all_ready(input logic [15:0] ins);
        int q[$];
        sources(ins, q);
        foreach (q[k]) if (!ready(q[k])) return 0;
        return 1;
    endfunction

    function automatic bit reads_reg(input logic [15:0] ins, input int r);
        int q[$];
        sources(ins, q);
        foreach (q[k]) if (q[k] == r) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        foreach (mp[r]) mp[r] = 0;
        mis.delete();
        mcnt = 0;
        merr = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, predict the response, advance the model across the edge.
    task automatic apply(input logic [15:0] a, input bit va, input logic [15:0] b,
                         input bit vb, input logic [19:0] w0, input logic [19:0] w1,
                         input bit br);
        exp_t e;
        bit   np[8];
        int   nis[$];
        int   op0, op1, rd0, rd1;
        bit   wr0, wr1, is0, is1;
        instr0 = a; valid0 = va; instr1 = b; valid1 = vb;
        wb0 = w0; wb1 = w1; is_branch_taken = br;
        op0 = int'(a[15:12]); rd0 = int'(a[10:8]);
        op1 = int'(b[15:12]); rd1 = int'(b[10:8]);
        wr0 = (op0 >= 1 && op0 <= 9);
        wr1 = (op1 >= 1 && op1 <= 9);
        is0 = va && all_ready(a) && !(wr0 && !ready(rd0)) && !br;
        is1 = is0 && vb && all_ready(b) && !(wr1 && !ready(rd1))
              && !(wr0 && reads_reg(b, rd0)) && !(wr0 && wr1 && rd0 == rd1)
              && op0 < 12;
        e.i0 = is0; e.i1 = is1; e.s0 = va && !is0; e.s1 = vb && !is1;
        for (int r = 0; r < 8; r++) e.pend[r] = mp[r];
        e.err = merr;
        expq.push_back(e);
        np = mp;
        for (int r = 0; r < 8; r++) if (wbhit(r)) np[r] = 0;
        if (br) foreach (mis[k]) np[mis[k]] = 0;
        if (is0 && wr0) begin np[rd0] = 1; nis.push_back(rd0); end
        if (is1 && wr1) begin np[rd1] = 1; nis.push_back(rd1); end
        if (va && !is0) mcnt = (mcnt < 64) ? mcnt + 1 : 64;
        else            mcnt = 0;
        if (mcnt == 64) merr = 1;
        @(posedge clk); #1;
        mp  = np;
        mis = nis;
    endtask

    task automatic idle();
        apply(16'h0, 0, 16'h0, 0, WB_NONE, WB_NONE, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid0 = 0; valid1 = 0; instr0 = '0; instr1 = '0;
        wb0 = WB_NONE; wb1 = WB_NONE; is_branch_taken = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every presented cycle against the predicted response.
    always @(negedge clk) begin : mon
        exp_t e, got;
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            got = {issue0, issue1, stall0, stall1, pending, timeout_err};
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL cycle @%0t: got i0=%b i1=%b s0=%b s1=%b pend=%h err=%b, expected i0=%b i1=%b s0=%b s1=%b pend=%h err=%b",
                         $time, got.i0, got.i1, got.s0, got.s1, got.pend, got.err,
                         e.i0, e.i1, e.s0, e.s1, e.pend, e.err);
            end
        end
    end

    initial begin
        // Reset state while reset is held.
        reset = 1'b1; valid0 = 1; valid1 = 1; instr0 = mk(1, 0, 1, 0, 0);
        instr1 = mk(1, 0, 2, 0, 0); wb0 = WB_NONE; wb1 = WB_NONE; is_branch_taken = 0;
        #12;
        chk("reset_pending", pending, 0);
        chk("reset_err", timeout_err, 0);
        chk("reset_outs", {issue0, issue1, stall0, stall1}, 0);
        do_reset();

        // Independent pair.
        apply(mk(1, 0, 1, 2, 3), 1, mk(1, 0, 4, 5, 6), 1, WB_NONE, WB_NONE, 0);
        chk("pair_pending", pending, 8'h12);

        // Intra-pair RAW: slot 1 reads slot 0's rd.
        do_reset();
        apply(mk(1, 0, 2, 0, 0), 1, mk(2, 1, 3, 2, 0), 1, WB_NONE, WB_NONE, 0);
        chk("raw01_pending", pending, 8'h04);

        // Scoreboard RAW resolved by writeback bypass.
        do_reset();
        apply(mk(1, 0, 3, 0, 0), 1, 16'h0, 0, WB_NONE, WB_NONE, 0);
        repeat (3) apply(mk(1, 0, 5, 3, 0), 1, 16'h0, 0, WB_NONE, WB_NONE, 0);
        apply(mk(1, 0, 5, 3, 0), 1, 16'h0, 0, WB_NONE, wbv(3, 16'h00AB), 0);
        chk("bypass_pending", pending, 8'h20);

        // Set wins over a same-cycle clear.
        do_reset();
        apply(mk(1, 0, 5, 0, 0), 1, 16'h0, 0, wbv(5, 16'h1234), WB_NONE, 0);
        chk("set_over_clear", pending, 8'h20);

        // Branch flush rolls back the previous cycle's writers.
        do_reset();
        apply(mk(1, 0, 2, 0, 0), 1, mk(1, 0, 6, 0, 0), 1, WB_NONE, WB_NONE, 0);
        chk("flush_pre", pending, 8'h44);
        apply(mk(1, 0, 1, 0, 0), 1, mk(1, 0, 3, 0, 0), 1, WB_NONE, WB_NONE, 1);
        chk("flush_rollback", pending, 8'h00);

        // Timeout, then asynchronous reset mid-stall.
        do_reset();
        apply(mk(1, 0, 7, 0, 0), 1, 16'h0, 0, WB_NONE, WB_NONE, 0);
        repeat (63) apply(mk(1, 0, 1, 7, 7), 1, mk(1, 0, 2, 0, 0), 1, WB_NONE, WB_NONE, 0);
        chk("timeout_63", timeout_err, 0);
        apply(mk(1, 0, 1, 7, 7), 1, mk(1, 0, 2, 0, 0), 1, WB_NONE, WB_NONE, 0);
        chk("timeout_64", timeout_err, 1);
        chk("stall_held", {stall0, stall1}, 2'b11);
        reset = 1'b1;
        #1;
        chk("async_pending", pending, 0);
        chk("async_err", timeout_err, 0);
        chk("async_outs", {issue0, issue1, stall0, stall1}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [19:0] a0, a1;
            a0 = ($urandom_range(0, 9) < 4) ? wbv($urandom_range(0, 7), 16'($urandom)) : WB_NONE;
            a1 = ($urandom_range(0, 9) < 4) ? wbv($urandom_range(0, 7), 16'($urandom)) : WB_NONE;
            apply(mk($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7)),
                  $urandom_range(0, 9) < 8,
                  mk($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7)),
                  $urandom_range(0, 9) < 8,
                  a0, a1, $urandom_range(0, 15) == 0);
            if (n % 500 == 499) do_reset();
        end
        idle();

        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d entries left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
